// File: rtl/psum_fifo_drain_if.sv
// Purpose: bundles the syncfifo FWFT read port and the writeback valid/ready port of psum_fifo_drain.
// Latency: none, wires only.
// Backpressure: out_ready from the writeback stage; FIFO pops are gated by fifo_empty.
interface psum_fifo_drain_if #(
    parameter int DWIDTH = 25,
    parameter int OWIDTH = 32
);
    logic              fifo_empty;
    logic [DWIDTH-1:0] fifo_rdata;
    logic              fifo_rden;
    logic [OWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_partial;
    logic              sat_flag;

    // Drain side: pops FIFO words and presents accumulated sums.
    modport slave (
        input  fifo_empty, fifo_rdata, out_ready,
        output fifo_rden, out_data, out_valid, out_partial, sat_flag
    );

    // Environment side: owns the FIFO and consumes the sums.
    modport master (
        output fifo_empty, fifo_rdata, out_ready,
        input  fifo_rden, out_data, out_valid, out_partial, sat_flag
    );
endinterface

// File: rtl/psum_fifo_drain.sv
// Purpose: pops signed partial sums from a FWFT FIFO and accumulates groups of acc_len words; ACC_SAT_EN selects saturating adds.
// Latency: a group of N words takes N+2 cycles (IDLE, N pops at 1/cycle, OUT) when out_ready is high.
// Backpressure: the sum is held in OUT until out_ready; no pops happen while waiting or while the FIFO is empty.
module psum_fifo_drain #(
    parameter int DWIDTH = 25,
    parameter int OWIDTH = 32,
    parameter int LWIDTH = 6
) (
    input  logic              clk,
    input  logic              rstn,
    psum_fifo_drain_if.slave  pif,
    input  logic [LWIDTH-1:0] acc_len,
    input  logic              flush,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LWIDTH-1:0] len;
    logic [LWIDTH-1:0] cnt;
    logic [OWIDTH-1:0] acc;
    logic [OWIDTH-1:0] base;
    logic [OWIDTH-1:0] word_ext;
    logic [OWIDTH-1:0] sum_nxt;
    logic              pop;
    logic              last;
    logic              close;
    logic              handshake;
    logic [OWIDTH-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_partial_q;

    // The size cast on a signed operand sign-extends the FIFO word.
    assign word_ext = OWIDTH'($signed(pif.fifo_rdata));

    // Pop/close decode; the first word of a group starts from zero instead of the stale acc.
    always_comb begin
        pop       = (state == ACC) && !pif.fifo_empty;
        base      = (cnt == '0) ? '0 : acc;
        last      = pop && (cnt == len - 1'b1);
        close     = (state == ACC) && (last || (flush && ((cnt != '0) || pop)));
        handshake = out_valid_q && pif.out_ready;
    end

`ifdef ACC_SAT_EN
    localparam logic [OWIDTH-1:0] SAT_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
    localparam logic [OWIDTH-1:0] SAT_MIN = {1'b1, {(OWIDTH-1){1'b0}}};

    logic [OWIDTH:0] sum_wide;
    logic            clip;
    logic            sat_grp;
    logic            sat_grp_nxt;
    logic            sat_flag_q;

    // One guard bit exposes signed overflow; clip towards the sign of the true result.
    always_comb begin
        sum_wide    = {base[OWIDTH-1], base} + {word_ext[OWIDTH-1], word_ext};
        clip        = sum_wide[OWIDTH] ^ sum_wide[OWIDTH-1];
        sum_nxt     = sum_wide[OWIDTH-1:0];
        if (clip) begin
            sum_nxt = sum_wide[OWIDTH] ? SAT_MIN : SAT_MAX;
        end
        sat_grp_nxt = ((cnt == '0) ? 1'b0 : sat_grp) | clip;
    end

    // Sticky per-group clip record, published with the sum and cleared on handshake.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            sat_grp    <= 1'b0;
            sat_flag_q <= 1'b0;
        end else begin
            if (pop) begin
                sat_grp <= sat_grp_nxt;
            end
            if (close) begin
                sat_flag_q <= pop ? sat_grp_nxt : sat_grp;
            end else if ((state == OUT) && handshake) begin
                sat_flag_q <= 1'b0;
            end
        end
    end

    assign pif.sat_flag = sat_flag_q;
`else
    // Plain two's-complement add; carries out of OWIDTH are dropped.
    always_comb begin
        sum_nxt = base + word_ext;
    end

    assign pif.sat_flag = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and FIFO pop strobe; rden is only raised in ACC with data present.
    always_comb begin
        state_nxt     = state;
        pif.fifo_rden = 1'b0;
        case (state)
            IDLE: begin
                if (!pif.fifo_empty) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                pif.fifo_rden = pop;
                if (close) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (handshake) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Group length latch, accumulation and the held output register.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            len           <= '0;
            cnt           <= '0;
            acc           <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_partial_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pif.fifo_empty) begin
                        len <= (acc_len == '0) ? LWIDTH'(1) : acc_len;
                        cnt <= '0;
                    end
                end
                ACC: begin
                    if (pop) begin
                        acc <= sum_nxt;
                        cnt <= cnt + 1'b1;
                    end
                    if (close) begin
                        out_data_q    <= pop ? sum_nxt : acc;
                        out_valid_q   <= 1'b1;
                        out_partial_q <= !last;
                    end
                end
                OUT: begin
                    if (handshake) begin
                        out_valid_q   <= 1'b0;
                        out_partial_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pif.out_data    = out_data_q;
    assign pif.out_valid   = out_valid_q;
    assign pif.out_partial = out_partial_q;
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_psum_fifo_drain.sv
// Bench for psum_fifo_drain: queue-based FWFT FIFO model plus arithmetic reference model.
// A second instance with OWIDTH=25 exercises the wrap/saturation boundary.
// Build with ACC_SAT_EN defined to check the saturating configuration.
module tb_psum_fifo_drain;
    localparam int DW  = 25;
    localparam int OW  = 32;
    localparam int LW  = 6;
    localparam int OWN = 25;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic [LW-1:0] acc_len;
    logic [LW-1:0] acc_len_n;
    logic          flush;
    logic          flush_n;
    logic          busy;
    logic          busy_n;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] fqn[$];
    logic          pop_seen   = 1'b0;
    logic          pop_seen_n = 1'b0;

    always #5 clk = ~clk;

    psum_fifo_drain_if #(.DWIDTH(DW), .OWIDTH(OW))  m  ();
    psum_fifo_drain_if #(.DWIDTH(DW), .OWIDTH(OWN)) mn ();

    psum_fifo_drain #(.DWIDTH(DW), .OWIDTH(OW), .LWIDTH(LW)) dut (
        .clk(clk), .rstn(rstn), .pif(m), .acc_len(acc_len), .flush(flush), .busy(busy)
    );

    psum_fifo_drain #(.DWIDTH(DW), .OWIDTH(OWN), .LWIDTH(LW)) dut_n (
        .clk(clk), .rstn(rstn), .pif(mn), .acc_len(acc_len_n), .flush(flush_n), .busy(busy_n)
    );

    // Pop strobes are sampled mid-cycle; a pop is never legal while the FIFO is empty.
    always @(negedge clk) begin
        pop_seen   = m.fifo_rden;
        pop_seen_n = mn.fifo_rden;
        if (!rstn) begin
            n_checks++;
            if (m.fifo_rden === 1'b1 && m.fifo_empty === 1'b1) begin
                n_fail++;
                $display("FAIL rden_while_empty actual=1 required=0 t=%0t", $time);
            end
        end
    end

    // FWFT FIFO model: head word is always presented; pops land just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (pop_seen && fq.size() > 0) void'(fq.pop_front());
        if (pop_seen_n && fqn.size() > 0) void'(fqn.pop_front());
        m.fifo_empty  = (fq.size() == 0);
        m.fifo_rdata  = (fq.size() == 0) ? '0 : fq[0];
        mn.fifo_empty = (fqn.size() == 0);
        mn.fifo_rdata = (fqn.size() == 0) ? '0 : fqn[0];
    end

    // Reference add on unbounded integers: clip to the signed range, or wrap modulo 2^ow.
    function automatic longint model_add(input longint s, input longint w, input int ow, output bit clipped);
        longint r;
        longint hi;
        longint lo;
        r       = s + w;
        hi      = (longint'(1) <<< (ow - 1)) - 1;
        lo      = -(longint'(1) <<< (ow - 1));
        clipped = 1'b0;
`ifdef ACC_SAT_EN
        if (r > hi) begin r = hi; clipped = 1'b1; end
        else if (r < lo) begin r = lo; clipped = 1'b1; end
`else
        if (r > hi) r = r - (longint'(1) <<< ow);
        else if (r < lo) r = r + (longint'(1) <<< ow);
`endif
        return r;
    endfunction

    function automatic longint rand_word();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        if ($urandom_range(0, 7) == 0) t = {1'b0, {(DW-1){1'b1}}};
        if ($urandom_range(0, 7) == 0) t = {1'b1, {(DW-1){1'b0}}};
        return longint'(t);
    endfunction

    task automatic test_reset();
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (m.out_data !== '0) begin n_fail++; $display("FAIL reset_out_data actual=%h required=0", m.out_data); end
        n_checks++; if (m.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid actual=%b required=0", m.out_valid); end
        n_checks++; if (m.out_partial !== 1'b0) begin n_fail++; $display("FAIL reset_out_partial actual=%b required=0", m.out_partial); end
        n_checks++; if (m.sat_flag !== 1'b0) begin n_fail++; $display("FAIL reset_sat_flag actual=%b required=0", m.sat_flag); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy actual=%b required=0", busy); end
        n_checks++; if (m.fifo_rden !== 1'b0) begin n_fail++; $display("FAIL reset_rden actual=%b required=0", m.fifo_rden); end
        @(posedge clk); #2;
        rstn = 1'b0;
    endtask

    task automatic test_basic();
        int            first;
        int            lastc;
        int            npop;
        int            nval;
        logic [OW-1:0] d;
        logic          p;
        first = -1; lastc = -1; npop = 0; nval = 0; d = '0; p = 1'b1;
        acc_len = LW'(4);
        m.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) fq.push_back(DW'(i));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m.fifo_rden) begin
                if (first < 0) first = c;
                lastc = c;
                npop++;
            end
            if (m.out_valid) begin
                nval++;
                d = m.out_data;
                p = m.out_partial;
            end
        end
        n_checks++; if (d !== 32'd10) begin n_fail++; $display("FAIL basic_sum actual=%h required=%h", d, 32'd10); end
        n_checks++; if (p !== 1'b0) begin n_fail++; $display("FAIL basic_partial actual=%b required=0", p); end
        n_checks++; if (npop != 4) begin n_fail++; $display("FAIL basic_pops actual=%0d required=4", npop); end
        n_checks++; if (lastc - first != 3) begin n_fail++; $display("FAIL basic_pop_span actual=%0d required=3", lastc - first); end
        n_checks++; if (nval != 1) begin n_fail++; $display("FAIL basic_valid_cycles actual=%0d required=1", nval); end
        @(posedge clk); #2;
    endtask

    task automatic test_backpressure();
        longint        s;
        bit            cl;
        logic [OW-1:0] e;
        int            got;
        int            w[3];
        w = '{-5, 2, 1};
        s = 0;
        acc_len = LW'(3);
        m.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fq.push_back(DW'(w[i]));
            s = model_add(s, longint'(w[i]), OW, cl);
        end
        e = s[OW-1:0];
        got = 0;
        for (int c = 0; c < 30 && got == 0; c++) begin
            @(negedge clk);
            got = m.out_valid;
        end
        n_checks++; if (got == 0) begin n_fail++; $display("FAIL bp_valid_timeout actual=0 required=1"); end
        @(posedge clk); #2;
        fq.push_back(DW'(99));
        flush = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (m.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c=%0d actual=%b required=1", c, m.out_valid); end
            n_checks++; if (m.out_data !== e) begin n_fail++; $display("FAIL bp_hold_data c=%0d actual=%h required=%h", c, m.out_data, e); end
            n_checks++; if (m.fifo_rden !== 1'b0) begin n_fail++; $display("FAIL bp_no_pop c=%0d actual=%b required=0", c, m.fifo_rden); end
            n_checks++; if (fq.size() != 1) begin n_fail++; $display("FAIL bp_occupancy c=%0d actual=%0d required=1", c, fq.size()); end
        end
        @(posedge clk); #2;
        flush = 1'b0;
        m.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (m.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release actual=%b required=0", m.out_valid); end
        @(posedge clk); #2;
        for (int c = 0; c < 20 && fq.size() != 0; c++) begin @(posedge clk); #2; end
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        got = 0;
        for (int c = 0; c < 20 && got == 0; c++) begin
            @(negedge clk);
            got = m.out_valid;
        end
        n_checks++; if (m.out_data !== 32'd99) begin n_fail++; $display("FAIL bp_drain_data actual=%h required=%h", m.out_data, 32'd99); end
        n_checks++; if (m.out_partial !== 1'b1) begin n_fail++; $display("FAIL bp_drain_partial actual=%b required=1", m.out_partial); end
        @(posedge clk); #2;
    endtask

    task automatic test_flush();
        int            lens[3];
        int            nws[3];
        int            rems[3];
        logic          expp[3];
        longint        s;
        longint        w;
        bit            cl;
        logic [OW-1:0] e;
        int            got;
        lens = '{8, 8, 2};
        nws  = '{3, 3, 2};
        rems = '{0, 1, 1};
        expp = '{1'b1, 1'b1, 1'b0};
        m.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            acc_len = LW'(lens[k]);
            s = 0;
            for (int i = 0; i < nws[k]; i++) begin
                w = rand_word();
                s = model_add(s, w, OW, cl);
                fq.push_back(DW'(w));
            end
            e = s[OW-1:0];
            for (int c = 0; c < 40 && fq.size() != rems[k]; c++) begin @(posedge clk); #2; end
            flush = 1'b1;
            @(posedge clk); #2;
            flush = 1'b0;
            got = 0;
            for (int c = 0; c < 20 && got == 0; c++) begin
                @(negedge clk);
                got = m.out_valid;
            end
            n_checks++; if (got == 0) begin n_fail++; $display("FAIL flush_timeout case=%0d actual=0 required=1", k); end
            n_checks++; if (m.out_data !== e) begin n_fail++; $display("FAIL flush_sum case=%0d actual=%h required=%h", k, m.out_data, e); end
            n_checks++; if (m.out_partial !== expp[k]) begin n_fail++; $display("FAIL flush_partial case=%0d actual=%b required=%b", k, m.out_partial, expp[k]); end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_flush_idle();
        flush = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++; if (m.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle_valid c=%0d actual=%b required=0", c, m.out_valid); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy c=%0d actual=%b required=0", c, busy); end
        end
        @(posedge clk); #2;
        flush = 1'b0;
    endtask

    task automatic test_len0();
        logic [OW-1:0] outs[$];
        int            np;
        np = 0;
        acc_len = '0;
        m.out_ready = 1'b1;
        fq.push_back(DW'(7));
        fq.push_back(DW'(9));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (m.out_valid && m.out_ready) begin
                outs.push_back(m.out_data);
                if (m.out_partial) np++;
            end
        end
        n_checks++; if (outs.size() != 2) begin n_fail++; $display("FAIL len0_groups actual=%0d required=2", outs.size()); end
        n_checks++; if (outs.size() > 0 && outs[0] !== 32'd7) begin n_fail++; $display("FAIL len0_first actual=%h required=%h", outs[0], 32'd7); end
        n_checks++; if (outs.size() > 1 && outs[1] !== 32'd9) begin n_fail++; $display("FAIL len0_second actual=%h required=%h", outs[1], 32'd9); end
        n_checks++; if (np != 0) begin n_fail++; $display("FAIL len0_partial actual=%0d required=0", np); end
        @(posedge clk); #2;
    endtask

    task automatic test_wrap();
        logic [DW-1:0]  wv[2];
        longint         s;
        bit             cl;
        bit             any;
        logic [OWN-1:0] e;
        int             got;
        wv = '{25'h0FFFFFF, 25'h1000000};
        acc_len_n = LW'(2);
        mn.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s = 0;
            any = 1'b0;
            for (int i = 0; i < 2; i++) begin
                fqn.push_back(wv[k]);
                s = model_add(s, longint'($signed(wv[k])), OWN, cl);
                any = any | cl;
            end
            e = s[OWN-1:0];
            got = 0;
            for (int c = 0; c < 20 && got == 0; c++) begin
                @(negedge clk);
                got = mn.out_valid;
            end
            n_checks++; if (got == 0) begin n_fail++; $display("FAIL wrap_timeout case=%0d actual=0 required=1", k); end
            n_checks++; if (mn.out_data !== e) begin n_fail++; $display("FAIL wrap_data case=%0d actual=%h required=%h", k, mn.out_data, e); end
            n_checks++; if (mn.sat_flag !== any) begin n_fail++; $display("FAIL wrap_sat_flag case=%0d actual=%b required=%b", k, mn.sat_flag, any); end
            @(posedge clk); #2;
        end
    endtask

    task automatic test_reset_mid();
        longint        w[6];
        longint        s;
        bit            cl;
        logic [OW-1:0] e;
        int            got;
        acc_len = LW'(4);
        m.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) w[i] = rand_word();
        for (int i = 0; i < 4; i++) fq.push_back(DW'(w[i]));
        for (int c = 0; c < 30 && fq.size() != 2; c++) begin @(posedge clk); #2; end
        rstn = 1'b1;
        #1;
        n_checks++; if (m.out_data !== '0) begin n_fail++; $display("FAIL rmid_out_data actual=%h required=0", m.out_data); end
        n_checks++; if (m.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid actual=%b required=0", m.out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy actual=%b required=0", busy); end
        n_checks++; if (m.fifo_rden !== 1'b0) begin n_fail++; $display("FAIL rmid_rden actual=%b required=0", m.fifo_rden); end
        repeat (2) @(posedge clk);
        #2;
        n_checks++; if (fq.size() != 2) begin n_fail++; $display("FAIL rmid_no_pop_in_reset actual=%0d required=2", fq.size()); end
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        fq.push_back(DW'(w[4]));
        fq.push_back(DW'(w[5]));
        s = 0;
        for (int i = 2; i < 6; i++) s = model_add(s, w[i], OW, cl);
        e = s[OW-1:0];
        got = 0;
        for (int c = 0; c < 30 && got == 0; c++) begin
            @(negedge clk);
            got = m.out_valid;
        end
        n_checks++; if (m.out_data !== e) begin n_fail++; $display("FAIL rmid_next_group actual=%h required=%h", m.out_data, e); end
        n_checks++; if (m.out_partial !== 1'b0) begin n_fail++; $display("FAIL rmid_partial actual=%b required=0", m.out_partial); end
        @(posedge clk); #2;
    endtask

    task automatic test_random();
        longint        pend[$];
        logic [OW-1:0] expq[$];
        longint        s;
        longint        w;
        bit            cl;
        int            len_eff;
        logic          hold;
        logic [OW-1:0] prevd;
        logic [OW-1:0] e;
        for (int b = 0; b < 6; b++) begin
            acc_len = LW'($urandom_range(0, 9));
            len_eff = (acc_len == '0) ? 1 : int'(acc_len);
            for (int g = 0; g < 3; g++) begin
                s = 0;
                for (int i = 0; i < len_eff; i++) begin
                    w = rand_word();
                    pend.push_back(w);
                    s = model_add(s, w, OW, cl);
                end
                expq.push_back(s[OW-1:0]);
            end
            hold = 1'b0;
            prevd = '0;
            for (int c = 0; c < 600 && expq.size() > 0; c++) begin
                @(negedge clk);
                if (m.out_valid && hold) begin
                    n_checks++; if (m.out_data !== prevd) begin n_fail++; $display("FAIL rand_stable b=%0d actual=%h required=%h", b, m.out_data, prevd); end
                end
                if (m.out_valid && m.out_ready) begin
                    e = expq.pop_front();
                    n_checks++; if (m.out_data !== e) begin n_fail++; $display("FAIL rand_sum b=%0d actual=%h required=%h", b, m.out_data, e); end
                    n_checks++; if (m.out_partial !== 1'b0) begin n_fail++; $display("FAIL rand_partial b=%0d actual=%b required=0", b, m.out_partial); end
                end
                hold  = m.out_valid && !m.out_ready;
                prevd = m.out_data;
                @(posedge clk); #2;
                if (pend.size() > 0 && $urandom_range(0, 3) != 0) fq.push_back(DW'(pend.pop_front()));
                m.out_ready = ($urandom_range(0, 2) != 0);
            end
            n_checks++; if (expq.size() != 0) begin n_fail++; $display("FAIL rand_timeout b=%0d actual=%0d required=0", b, expq.size()); end
            expq.delete();
            pend.delete();
            m.out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        acc_len      = LW'(4);
        acc_len_n    = LW'(2);
        flush        = 1'b0;
        flush_n      = 1'b0;
        m.out_ready  = 1'b1;
        mn.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_flush_idle();
        test_len0();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
